// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 round-constant fetch path.
//   K_LENGTH_DEFAULT : number of round constants in one compression pass
//   fetch_state_t    : sequencer state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   prefetch_depth() : prefetch FIFO depth needed to cover a given memory
//                      read latency at full throughput
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int K_LENGTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    // One slot per cycle of read latency, one for the entry being presented
    // and one so a pop and the next issue can overlap without a bubble.
    function automatic int prefetch_depth(input int mem_latency);
        return mem_latency + 2;
    endfunction

endpackage

// File: rtl/k_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// k_prefetch_fifo
// Synchronous DEPTH-entry FIFO holding returned round constants together with
// the address tag they were read from.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   push           : write push_data/push_tag at the tail
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop in the same cycle
//   count          : number of stored entries
//   head_data      : data of the head entry (meaningful when count != 0)
//   head_tag       : tag of the head entry (meaningful when count != 0)
// The writer guarantees it never pushes into a full FIFO, so there is no
// full indication.
// ---------------------------------------------------------------------------
module k_prefetch_fifo #(
    parameter int DEPTH = 3,
    parameter int DW    = 32,
    parameter int TW    = 6,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [TW-1:0] push_tag,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head_data,
    output logic [TW-1:0] head_tag
);

    logic [DW-1:0] data_mem [DEPTH];
    logic [TW-1:0] tag_mem  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            // Simultaneous push and pop leave the count unchanged.
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed when count != 0.
    always_ff @(posedge clock) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            tag_mem[wr_ptr]  <= push_tag;
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_tag  = tag_mem[rd_ptr];

endmodule

// File: rtl/k_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// k_fetch_ctrl
// Walks the SHA-256 round-constant memory once per compression pass, hiding
// the memory read latency behind a small prefetch FIFO, and hands constants
// to the round datapath.
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   start                 : begin a pass (sampled only in IDLE)
//   abort                 : cancel the current pass (ignored in IDLE)
//   k_read_en, k_address  : read strobe and address to the constant memory
//   k_data                : read data, valid MEM_LATENCY cycles after strobe
//   k_valid, k_ready      : handshake for cur_k_value / k_round
//   cur_k_value, k_round  : constant at the FIFO head and its round index
//   address_read_complete : level, all K_LENGTH reads issued this pass
//   busy                  : sequencer is not IDLE
//   done                  : one-cycle pulse after the last constant is taken
//   dbg_state             : current sequencer state (fetch_state_t encoding)
//
// Handshake: a transfer happens in every cycle where k_valid && k_ready are
// both high. k_valid depends only on registered state, never on k_ready.
// While k_valid is high and k_ready is low, cur_k_value and k_round hold.
// ---------------------------------------------------------------------------
module k_fetch_ctrl
    import sha256_pkg::*;
#(
    parameter int K_LENGTH    = K_LENGTH_DEFAULT,
    parameter int MEM_LATENCY = 1,
    localparam int AW         = $clog2(K_LENGTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    output logic          k_read_en,
    output logic [AW-1:0] k_address,
    input  logic [31:0]   k_data,
    output logic          k_valid,
    input  logic          k_ready,
    output logic [31:0]   cur_k_value,
    output logic [AW-1:0] k_round,
    output logic          address_read_complete,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    localparam int DEPTH = prefetch_depth(MEM_LATENCY);
    localparam int CW    = AW + 1;                 // reaches K_LENGTH without wrap
    localparam int FCW   = $clog2(DEPTH + 1);
    localparam int OW    = FCW + 1;

    fetch_state_t    state;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   round_cnt;
    logic            arc_q;

    // Latency shift register: one valid bit and address tag per strobe.
    logic [MEM_LATENCY-1:0] tag_vld;
    logic [AW-1:0]          tag_addr [MEM_LATENCY];

    logic [FCW-1:0]  fifo_count;
    logic [FCW-1:0]  inflight;
    logic [OW-1:0]   occupancy;
    logic [31:0]     head_data;
    logic [AW-1:0]   head_tag;
    logic            strobe;
    logic            xfer;
    logic            last_xfer;
    logic            fifo_push;
    logic            fifo_flush;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + FCW'(tag_vld[i]);
        end
    end

    // Reads still in the memory pipeline already own a FIFO slot, so capping
    // fifo_count + inflight at DEPTH rules out overflow without a stall path.
    assign occupancy = OW'(fifo_count) + OW'(inflight);
    assign strobe    = (state == RUN) && (issued < CW'(K_LENGTH))
                       && (occupancy < OW'(DEPTH));

    assign xfer       = k_valid && k_ready;
    assign last_xfer  = xfer && (round_cnt == CW'(K_LENGTH - 1));
    // Returning data is only kept while a pass is running; in DRAIN it is
    // dropped on the floor.
    assign fifo_push  = tag_vld[MEM_LATENCY-1] && (state == RUN);
    assign fifo_flush = ((state == IDLE) && start) || ((state == RUN) && abort);

    k_prefetch_fifo #(
        .DEPTH (DEPTH),
        .DW    (32),
        .TW    (AW)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (k_data),
        .push_tag  (tag_addr[MEM_LATENCY-1]),
        .pop       (xfer),
        .flush     (fifo_flush),
        .count     (fifo_count),
        .head_data (head_data),
        .head_tag  (head_tag)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_addr[i] <= '0;
            end
        end else begin
            tag_vld[0]  <= strobe;
            tag_addr[0] <= issued[AW-1:0];
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_addr[i] <= tag_addr[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            issued    <= '0;
            round_cnt <= '0;
            arc_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        issued    <= '0;
                        round_cnt <= '0;
                        arc_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (strobe) begin
                        issued <= issued + 1'b1;
                        if (issued == CW'(K_LENGTH - 1)) arc_q <= 1'b1;
                    end
                    if (xfer) round_cnt <= round_cnt + 1'b1;
                    // abort wins over a final transfer in the same cycle
                    if (abort)          state <= DRAIN;
                    else if (last_xfer) state <= DONE;
                end
                DRAIN: begin
                    if (inflight == '0) state <= IDLE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign k_read_en             = strobe;
    assign k_address             = issued[AW-1:0];
    assign k_valid               = (fifo_count != '0);
    assign cur_k_value           = k_valid ? head_data : '0;
    // The head tag is the address the entry was read from, i.e. its round.
    assign k_round               = k_valid ? head_tag : round_cnt[AW-1:0];
    assign address_read_complete = arc_q;
    assign busy                  = (state != IDLE);
    assign done                  = (state == DONE);
    assign dbg_state             = state;

endmodule
